// File: rtl/adc_pkg.sv
// -----------------------------------------------------------------------------
// adc_pkg
// Types and constants shared by the ramp ADC and the sample averager.
//   ADC_DATA_WIDTH : width of one sample word ({4'b0, code[7:0], 4'b0}).
//   adc_sample_t   : one sample word.
//   avg_state_t    : averager FSM state encoding.
// -----------------------------------------------------------------------------
package adc_pkg;

  localparam int ADC_DATA_WIDTH = 16;

  typedef logic [ADC_DATA_WIDTH-1:0] adc_sample_t;

  typedef enum logic {
    AVG_IDLE,
    AVG_ACCUM
  } avg_state_t;

endpackage : adc_pkg

// File: rtl/adc_sample_averager.sv
// -----------------------------------------------------------------------------
// adc_sample_averager
// Consumes data_ready/adc_in sample pairs from the ramp ADC, accumulates
// blocks of 2^LOG2_SAMPLES samples and publishes the truncated block mean
// together with the block min and max, flagged by a one-cycle avg_valid.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   enable       in   low aborts the current block and holds the block idle
//   data_ready   in   one-cycle strobe, adc_in valid in that cycle
//   adc_in       in   sample value
//   avg_out      out  block mean (sum >> LOG2_SAMPLES, truncated)
//   min_out      out  smallest sample of the last completed block
//   max_out      out  largest sample of the last completed block
//   avg_valid    out  one-cycle pulse when avg/min/max update
//   sample_count out  samples accepted in the current block (never 2^LOG2)
// -----------------------------------------------------------------------------
module adc_sample_averager
  import adc_pkg::*;
#(
  parameter int DATA_WIDTH   = ADC_DATA_WIDTH,
  parameter int LOG2_SAMPLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    data_ready,
  input  logic [DATA_WIDTH-1:0]   adc_in,
  output logic [DATA_WIDTH-1:0]   avg_out,
  output logic [DATA_WIDTH-1:0]   min_out,
  output logic [DATA_WIDTH-1:0]   max_out,
  output logic                    avg_valid,
  output logic [LOG2_SAMPLES-1:0] sample_count
);

  if (LOG2_SAMPLES < 1 || LOG2_SAMPLES > 8) begin : g_bad_log2_samples
    $error("adc_sample_averager: LOG2_SAMPLES=%0d outside 1..8", LOG2_SAMPLES);
  end

  // Sum of 2^LOG2_SAMPLES full-scale samples fits exactly, so no saturation.
  localparam int ACC_W = DATA_WIDTH + LOG2_SAMPLES;

  localparam logic [LOG2_SAMPLES-1:0] CNT_ONE  = LOG2_SAMPLES'(1);
  localparam logic [LOG2_SAMPLES-1:0] CNT_LAST = '1;

  avg_state_t              r_state;
  avg_state_t              w_next_state;
  logic                    w_accept;
  logic                    w_clear;

  logic [ACC_W-1:0]        r_acc;
  logic [LOG2_SAMPLES-1:0] r_count;
  logic [DATA_WIDTH-1:0]   r_run_min;
  logic [DATA_WIDTH-1:0]   r_run_max;

  logic [DATA_WIDTH-1:0]   r_avg;
  logic [DATA_WIDTH-1:0]   r_min;
  logic [DATA_WIDTH-1:0]   r_max;
  logic                    r_valid;

  logic                    w_first;
  logic                    w_last;
  logic [ACC_W-1:0]        w_sum;
  logic [DATA_WIDTH-1:0]   w_min_next;
  logic [DATA_WIDTH-1:0]   w_max_next;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= AVG_IDLE;
    else       r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and datapath controls. IDLE leaves on the same cycle that
  // enable rises, so a sample in the first enabled cycle is still accepted.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      AVG_IDLE: begin
        if (enable) begin
          w_next_state = AVG_ACCUM;
          w_accept     = data_ready;
        end else begin
          w_clear = 1'b1;
        end
      end
      AVG_ACCUM: begin
        if (!enable) begin
          // Partial block is discarded; a coincident sample is dropped.
          w_next_state = AVG_IDLE;
          w_clear      = 1'b1;
        end else begin
          w_accept = data_ready;
        end
      end
      default: w_next_state = AVG_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Running sum and extremes including the sample presented this cycle.
  // The first sample of a block loads min and max unconditionally.
  // ---------------------------------------------------------------------------
  assign w_first    = (r_count == '0);
  assign w_last     = w_accept && (r_count == CNT_LAST);
  assign w_sum      = r_acc + {{LOG2_SAMPLES{1'b0}}, adc_in};
  assign w_min_next = (w_first || (adc_in < r_run_min)) ? adc_in : r_run_min;
  assign w_max_next = (w_first || (adc_in > r_run_max)) ? adc_in : r_run_max;

  // ---------------------------------------------------------------------------
  // Accumulation and publish. On the last sample the block is published and
  // the accumulator restarts, so a sample in the avg_valid cycle opens the
  // next block with nothing lost.
  // ---------------------------------------------------------------------------
  // NOTE: every register, including the running min/max that the first-sample
  // load would otherwise cover, is reset so the block never powers up to X.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_run_min <= '0;
      r_run_max <= '0;
      r_avg     <= '0;
      r_min     <= '0;
      r_max     <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_clear) begin
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_last) begin
        r_avg   <= w_sum[ACC_W-1:LOG2_SAMPLES];
        r_min   <= w_min_next;
        r_max   <= w_max_next;
        r_valid <= 1'b1;
        r_acc   <= '0;
        r_count <= '0;
      end else if (w_accept) begin
        r_acc     <= w_sum;
        r_count   <= r_count + CNT_ONE;
        r_run_min <= w_min_next;
        r_run_max <= w_max_next;
      end
    end
  end

  assign avg_out      = r_avg;
  assign min_out      = r_min;
  assign max_out      = r_max;
  assign avg_valid    = r_valid;
  assign sample_count = r_count;

endmodule : adc_sample_averager

// File: tb/tb_adc_sample_averager.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_averager
// Directed self-checking bench for adc_sample_averager with 4-sample blocks.
// Inputs change on the falling edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_adc_sample_averager;

  localparam int DW = 16;
  localparam int L2 = 2;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          data_ready;
  logic [DW-1:0] adc_in;
  logic [DW-1:0] avg_out;
  logic [DW-1:0] min_out;
  logic [DW-1:0] max_out;
  logic          avg_valid;
  logic [L2-1:0] sample_count;

  int n_checks = 0;
  int n_err    = 0;

  adc_sample_averager #(
    .DATA_WIDTH  (DW),
    .LOG2_SAMPLES(L2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .data_ready  (data_ready),
    .adc_in      (adc_in),
    .avg_out     (avg_out),
    .min_out     (min_out),
    .max_out     (max_out),
    .avg_valid   (avg_valid),
    .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle data_ready pulse; returns on the falling edge after the
  // capturing rising edge, where the result of that sample is visible.
  task automatic send(input logic [DW-1:0] v);
    @(negedge clk);
    data_ready = 1'b1;
    adc_in     = v;
    @(negedge clk);
    data_ready = 1'b0;
    adc_in     = 16'hDEAD;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_result(input string tag, input logic [31:0] avg,
                              input logic [31:0] mn, input logic [31:0] mx);
    check({tag, " valid"}, 32'(avg_valid), 1);
    check({tag, " avg"},   32'(avg_out),   avg);
    check({tag, " min"},   32'(min_out),   mn);
    check({tag, " max"},   32'(max_out),   mx);
    check({tag, " count"}, 32'(sample_count), 0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pulses;

    reset      = 1'b1;
    enable     = 1'b0;
    data_ready = 1'b0;
    adc_in     = '0;

    // Reset state
    #3;
    check("rst avg",   32'(avg_out),      0);
    check("rst min",   32'(min_out),      0);
    check("rst max",   32'(max_out),      0);
    check("rst valid", 32'(avg_valid),    0);
    check("rst count", 32'(sample_count), 0);
    idle(2);
    reset = 1'b0;

    // 1: basic block, samples spaced 10 cycles apart
    enable = 1'b1;
    send(16'h0100); idle(10);
    send(16'h0200);
    check("t1 count after 2", 32'(sample_count), 2);
    idle(10);
    send(16'h0300); idle(10);
    send(16'h0400);
    check_result("t1", 'h0280, 'h0100, 'h0400);
    @(negedge clk);
    check("t1 valid one cycle", 32'(avg_valid), 0);

    // 2: truncation and full scale
    send(16'h0010); send(16'h0010); send(16'h0010); send(16'h0020);
    check_result("t2 trunc", 'h0014, 'h0010, 'h0020);
    repeat (4) send(16'h0FF0);
    check_result("t2 full", 'h0FF0, 'h0FF0, 'h0FF0);

    // 3: data_ready every cycle, 8 samples -> two back-to-back blocks
    pulses = 0;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (avg_valid) pulses++;
      check($sformatf("t3 valid c%0d", i), 32'(avg_valid), (i == 4 || i == 8) ? 1 : 0);
      if (i == 4) check("t3 avg1", 32'(avg_out), 'h0028);
      if (i == 8) begin
        check("t3 avg2", 32'(avg_out), 'h0068);
        check("t3 min2", 32'(min_out), 'h0050);
        check("t3 max2", 32'(max_out), 'h0080);
      end
      if (i < 8) begin
        data_ready = 1'b1;
        adc_in     = 16'((i + 1) * 'h10);
      end else begin
        data_ready = 1'b0;
      end
    end
    check("t3 pulses", 32'(pulses), 2);

    // 4: enable dropped mid-block, coincident sample dropped
    send(16'h0111); send(16'h0222);
    check("t4 count partial", 32'(sample_count), 2);
    @(negedge clk);
    enable     = 1'b0;
    data_ready = 1'b1;
    adc_in     = 16'hFFFF;
    @(negedge clk);
    data_ready = 1'b0;
    check("t4 abort valid", 32'(avg_valid),    0);
    check("t4 abort count", 32'(sample_count), 0);
    check("t4 hold avg",    32'(avg_out),      'h0068);
    check("t4 hold min",    32'(min_out),      'h0050);
    check("t4 hold max",    32'(max_out),      'h0080);
    @(negedge clk);
    enable = 1'b1;
    repeat (4) send(16'h0200);
    check_result("t4", 'h0200, 'h0200, 'h0200);

    // 5: async reset between edges mid-block
    send(16'h0300); send(16'h0300);
    check("t5 count partial", 32'(sample_count), 2);
    #2;
    reset = 1'b1;
    #1;
    check("t5 rst avg",   32'(avg_out),      0);
    check("t5 rst min",   32'(min_out),      0);
    check("t5 rst max",   32'(max_out),      0);
    check("t5 rst valid", 32'(avg_valid),    0);
    check("t5 rst count", 32'(sample_count), 0);
    @(negedge clk);
    reset = 1'b0;
    send(16'h0010); send(16'h0020); send(16'h0030); send(16'h0040);
    check_result("t5", 'h0028, 'h0010, 'h0040);

    // 6: disabled for 100 cycles with data_ready toggling
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check($sformatf("t6 valid c%0d", i), 32'(avg_valid),    0);
      check($sformatf("t6 count c%0d", i), 32'(sample_count), 0);
      data_ready = (i % 2 == 0);
      adc_in     = 16'(i * 'h111);
    end
    @(negedge clk);
    data_ready = 1'b0;
    check("t6 hold avg", 32'(avg_out), 'h0028);
    check("t6 hold min", 32'(min_out), 'h0010);
    check("t6 hold max", 32'(max_out), 'h0040);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_adc_sample_averager
